// File: rtl/rdret_1r1we_rl2_pkg.sv
// Shared types for the 1r1we rl2 read-return path: one captured return entry.
package pkg_1r1we_rl2;
  localparam int P_WIDTH   = 32;
  localparam int P_BITPADR = 14;
  localparam int P_ENT_W   = P_WIDTH + P_BITPADR + 3;

  typedef struct packed {
    logic [P_WIDTH-1:0]   dout;
    logic                 fwrd;
    logic                 serr;
    logic                 derr;
    logic [P_BITPADR-1:0] padr;
  } rd_ent_t;
endpackage

// File: rtl/rdret_1r1we_rl2_if.sv
// Issue, return and consumer signals of the read-return stage.
interface rdret_1r1we_rl2_if #(
  parameter int WIDTH   = 32,
  parameter int BITADDR = 13,
  parameter int BITPADR = 14
);
  logic               ready;
  logic               cl_read;
  logic [BITADDR-1:0] cl_rd_adr;
  logic               cl_rd_gnt;
  logic               read;
  logic [BITADDR-1:0] rd_adr;
  logic               rd_vld;
  logic [WIDTH-1:0]   rd_dout;
  logic               rd_fwrd;
  logic               rd_serr;
  logic               rd_derr;
  logic [BITPADR-1:0] rd_padr;
  logic               out_vld;
  logic               out_rdy;
  logic [WIDTH-1:0]   out_dout;
  logic               out_fwrd;
  logic               out_serr;
  logic               out_derr;
  logic [BITPADR-1:0] out_padr;

  modport slave (
    input  ready, cl_read, cl_rd_adr, rd_vld, rd_dout, rd_fwrd, rd_serr, rd_derr, rd_padr, out_rdy,
    output cl_rd_gnt, read, rd_adr, out_vld, out_dout, out_fwrd, out_serr, out_derr, out_padr
  );
  modport master (
    output ready, cl_read, cl_rd_adr, rd_vld, rd_dout, rd_fwrd, rd_serr, rd_derr, rd_padr, out_rdy,
    input  cl_rd_gnt, read, rd_adr, out_vld, out_dout, out_fwrd, out_serr, out_derr, out_padr
  );
endinterface

// File: rtl/rdret_1r1we_rl2_fifo.sv
// Generic flop-array FIFO; a push at full is accepted only when a pop frees the slot.
module rdret_fifo_1r1we #(
  parameter int DW       = 8,
  parameter int DEPTH    = 8,
  parameter int BITDEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DW-1:0]     din,
  input  logic              pop,
  output logic [DW-1:0]     dout,
  output logic              full,
  output logic              empty,
  output logic [BITDEPTH:0] count
);
  localparam logic [BITDEPTH:0]   FULL_CNT = (BITDEPTH+1)'(DEPTH);
  localparam logic [BITDEPTH-1:0] LAST_PTR = BITDEPTH'(DEPTH-1);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [BITDEPTH-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [BITDEPTH:0]        cnt_q, cnt_d;
  logic                     do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/rdret_1r1we_rl2.sv
// Read-return stage: credit-gated read issue, return FIFO with valid/ready,
// saturating ECC error counters and a sticky overflow flag.
module rdret_1r1we_rl2 import pkg_1r1we_rl2::*; #(
  parameter int WIDTH    = P_WIDTH,
  parameter int BITADDR  = 13,
  parameter int BITPADR  = P_BITPADR,
  parameter int DEPTH    = 8,
  parameter int BITDEPTH = 3,
  parameter int BITCNT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  rdret_1r1we_rl2_if.slave  bus,
  output logic [BITCNT-1:0] serr_cnt,
  output logic [BITCNT-1:0] derr_cnt,
  output logic              ovf
);
  localparam logic [BITDEPTH:0] CRED_MAX = (BITDEPTH+1)'(DEPTH);
  localparam logic [BITCNT-1:0] CNT_MAX  = '1;

  rd_ent_t           push_ent, head_ent;
  logic              fifo_full, fifo_empty;
  logic [BITDEPTH:0] fifo_cnt;
  logic              gnt, pop;

  logic [BITDEPTH:0] credit_q, credit_d;
  logic [BITCNT-1:0] serr_cnt_q, serr_cnt_d, derr_cnt_q, derr_cnt_d;
  logic              ovf_q, ovf_d;

  // Issue path is purely combinational so grant and read are cycle-exact.
  assign gnt           = bus.cl_read & bus.ready & (credit_q != '0);
  assign bus.cl_rd_gnt = gnt;
  assign bus.read      = gnt;
  assign bus.rd_adr    = BITADDR'(bus.cl_rd_adr);

  assign pop = bus.out_rdy & ~fifo_empty;

  assign push_ent.dout = P_WIDTH'(bus.rd_dout);
  assign push_ent.fwrd = bus.rd_fwrd;
  assign push_ent.serr = bus.rd_serr;
  assign push_ent.derr = bus.rd_derr;
  assign push_ent.padr = P_BITPADR'(bus.rd_padr);

  rdret_fifo_1r1we #(
    .DW       (P_ENT_W),
    .DEPTH    (DEPTH),
    .BITDEPTH (BITDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rd_vld),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head_ent),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign bus.out_vld  = (fifo_cnt != '0);
  assign bus.out_dout = WIDTH'(head_ent.dout);
  assign bus.out_fwrd = head_ent.fwrd;
  assign bus.out_serr = head_ent.serr;
  assign bus.out_derr = head_ent.derr;
  assign bus.out_padr = BITPADR'(head_ent.padr);

  assign serr_cnt = serr_cnt_q;
  assign derr_cnt = derr_cnt_q;
  assign ovf      = ovf_q;

  always_comb begin
    credit_d   = credit_q;
    serr_cnt_d = serr_cnt_q;
    derr_cnt_d = derr_cnt_q;
    // Clamp at DEPTH so unsolicited returns cannot inflate the credit pool.
    case ({gnt, pop})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   if (credit_q != CRED_MAX) credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
    if (bus.rd_vld & bus.rd_serr & (serr_cnt_q != CNT_MAX)) serr_cnt_d = serr_cnt_q + 1'b1;
    if (bus.rd_vld & bus.rd_derr & (derr_cnt_q != CNT_MAX)) derr_cnt_d = derr_cnt_q + 1'b1;
    ovf_d = ovf_q | (bus.rd_vld & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q   <= CRED_MAX;
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      serr_cnt_q <= serr_cnt_d;
      derr_cnt_q <= derr_cnt_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_rdret_1r1we_rl2.sv
// Scoreboard bench for rdret_1r1we_rl2 with a latency-2 memory model and a BITCNT=2 twin.
module tb_rdret_1r1we_rl2;
  import pkg_1r1we_rl2::*;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rdret_1r1we_rl2_if #(.WIDTH(32), .BITADDR(13), .BITPADR(14)) ifa ();
  rdret_1r1we_rl2_if #(.WIDTH(32), .BITADDR(13), .BITPADR(14)) ifb ();

  logic [15:0] serr_a, derr_a;
  logic [1:0]  serr_b, derr_b;
  logic        ovf_a, ovf_b;

  rdret_1r1we_rl2 #(.DEPTH(DEPTH), .BITDEPTH(3), .BITCNT(16)) dut (
    .clk(clk), .rst(rst), .bus(ifa.slave), .serr_cnt(serr_a), .derr_cnt(derr_a), .ovf(ovf_a));
  rdret_1r1we_rl2 #(.DEPTH(DEPTH), .BITDEPTH(3), .BITCNT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave), .serr_cnt(serr_b), .derr_cnt(derr_b), .ovf(ovf_b));

  assign ifb.ready     = ifa.ready;
  assign ifb.cl_read   = ifa.cl_read;
  assign ifb.cl_rd_adr = ifa.cl_rd_adr;
  assign ifb.rd_vld    = ifa.rd_vld;
  assign ifb.rd_dout   = ifa.rd_dout;
  assign ifb.rd_fwrd   = ifa.rd_fwrd;
  assign ifb.rd_serr   = ifa.rd_serr;
  assign ifb.rd_derr   = ifa.rd_derr;
  assign ifb.rd_padr   = ifa.rd_padr;
  assign ifb.out_rdy   = ifa.out_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: mirrors FIFO contents; pop on handshake, push unless the FIFO would overflow.
  rd_ent_t sbq[$];
  always @(negedge clk) begin
    rd_ent_t e;
    if (rst) sbq.delete();
    else begin
      chk("out_vld", ifa.out_vld, sbq.size() != 0);
      if (ifa.out_vld && ifa.out_rdy && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("head_dout", ifa.out_dout, e.dout);
        chk("head_meta", {ifa.out_fwrd, ifa.out_serr, ifa.out_derr, ifa.out_padr},
            {e.fwrd, e.serr, e.derr, e.padr});
      end
      if (ifa.rd_vld && sbq.size() < DEPTH) begin
        e.dout = ifa.rd_dout; e.fwrd = ifa.rd_fwrd; e.serr = ifa.rd_serr;
        e.derr = ifa.rd_derr; e.padr = ifa.rd_padr;
        sbq.push_back(e);
      end
    end
  end

  // Latency-2 memory model driven from the stimulus thread.
  logic        mv [2];
  rd_ent_t     me [2];
  logic [31:0] next_data;
  int          gcnt;
  logic        last_gnt;

  task automatic step();
    logic issued;
    @(negedge clk);
    issued   = ifa.read;
    last_gnt = ifa.cl_rd_gnt;
    if (last_gnt) gcnt++;
    @(posedge clk);
    #1;
    ifa.rd_vld  = mv[1];
    ifa.rd_dout = mv[1] ? me[1].dout : '0;
    ifa.rd_fwrd = mv[1] ? me[1].fwrd : 1'b0;
    ifa.rd_serr = mv[1] ? me[1].serr : 1'b0;
    ifa.rd_derr = mv[1] ? me[1].derr : 1'b0;
    ifa.rd_padr = mv[1] ? me[1].padr : '0;
    mv[1] = mv[0];
    me[1] = me[0];
    mv[0] = issued;
    me[0].dout = next_data;
    me[0].fwrd = next_data[0];
    me[0].serr = 1'b0;
    me[0].derr = 1'b0;
    me[0].padr = 14'(next_data + 32'h100);
    if (issued) next_data++;
  endtask

  task automatic fret(input logic [31:0] d, input logic s, input logic e);
    ifa.rd_vld = 1'b1; ifa.rd_dout = d; ifa.rd_fwrd = 1'b0;
    ifa.rd_serr = s; ifa.rd_derr = e; ifa.rd_padr = 14'(d);
    step();
  endtask

  task automatic drain(input string nm);
    ifa.cl_read = 1'b0;
    ifa.out_rdy = 1'b1;
    for (int i = 0; i < 40 && (ifa.out_vld || mv[0] || mv[1]); i++) step();
    step();
    chk(nm, ifa.out_vld, 1'b0);
    ifa.out_rdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.ready = 1'b0; ifa.cl_read = 1'b0; ifa.cl_rd_adr = '0; ifa.out_rdy = 1'b0;
    ifa.rd_vld = 1'b0; ifa.rd_dout = '0; ifa.rd_fwrd = 1'b0;
    ifa.rd_serr = 1'b0; ifa.rd_derr = 1'b0; ifa.rd_padr = '0;
    mv[0] = 1'b0; mv[1] = 1'b0; me[0] = '0; me[1] = '0;
    next_data = '0; gcnt = 0; last_gnt = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_out_vld", ifa.out_vld, 1'b0);
    chk("rst_out_dout", ifa.out_dout, 32'h0);
    chk("rst_serr", serr_a, 16'h0);
    chk("rst_derr", derr_a, 16'h0);
    chk("rst_ovf", ovf_a, 1'b0);

    // Eight grants from reset credit, ninth blocked with consumer stalled.
    next_data = 32'hA0; ifa.ready = 1'b1; ifa.cl_read = 1'b1;
    ifa.cl_rd_adr = 13'h5; gcnt = 0;
    step();
    chk("rd_adr", ifa.rd_adr, 13'h5);
    repeat (8) step();
    chk("grants_from_reset", gcnt, 8);
    chk("gnt9_low", last_gnt, 1'b0);
    ifa.cl_read = 1'b0;
    repeat (3) step();
    chk("full_head", ifa.out_dout, 32'hA0);
    chk("full_no_ovf", ovf_a, 1'b0);

    // Full FIFO draining while issuing: one grant per freed slot.
    gcnt = 0; ifa.cl_read = 1'b1; ifa.out_rdy = 1'b1;
    repeat (16) step();
    chk("grant_per_pop", gcnt, 15);
    chk("stream_no_ovf", ovf_a, 1'b0);
    drain("drain_stream");

    // No bypass: empty-FIFO return appears one cycle later.
    ifa.rd_vld = 1'b1; ifa.rd_dout = 32'h1234; ifa.rd_fwrd = 1'b1; ifa.rd_padr = 14'h55;
    chk("no_bypass", ifa.out_vld, 1'b0);
    step();
    chk("lat1_vld", ifa.out_vld, 1'b1);
    chk("lat1_dout", ifa.out_dout, 32'h1234);
    chk("lat1_fwrd", ifa.out_fwrd, 1'b1);
    chk("lat1_padr", ifa.out_padr, 14'h55);
    ifa.out_rdy = 1'b1;
    step();
    ifa.out_rdy = 1'b0;

    // Credit back at DEPTH; fill, then overflow.
    next_data = 32'hB0; gcnt = 0; ifa.cl_read = 1'b1;
    repeat (10) step();
    chk("grants_refill", gcnt, 8);
    ifa.cl_read = 1'b0;
    repeat (3) step();
    chk("pre_ovf", ovf_a, 1'b0);
    fret(32'hEE, 1'b1, 1'b0);
    chk("ovf_set", ovf_a, 1'b1);
    chk("ovf_set_b", ovf_b, 1'b1);
    chk("ovf_head_kept", ifa.out_dout, 32'hB0);
    repeat (2) step();
    chk("ovf_sticky", ovf_a, 1'b1);
    chk("ovf_head_kept2", ifa.out_dout, 32'hB0);
    chk("drop_serr_counted", serr_a, 16'h1);
    ifa.out_rdy = 1'b1;
    fret(32'hC0, 1'b0, 1'b0);
    ifa.out_rdy = 1'b0;
    chk("full_pushpop_head", ifa.out_dout, 32'hB1);
    chk("full_pushpop_ovf", ovf_a, 1'b1);
    drain("drain_ovf");

    // Error counters and BITCNT=2 saturation.
    ifa.out_rdy = 1'b1;
    fret(32'h11, 1'b1, 1'b0);
    fret(32'h22, 1'b1, 1'b0);
    fret(32'h33, 1'b0, 1'b1);
    fret(32'h44, 1'b0, 1'b0);
    step();
    chk("serr_cnt3", serr_a, 16'd3);
    chk("derr_cnt1", derr_a, 16'd1);
    chk("serr_b3", serr_b, 2'd3);
    chk("derr_b1", derr_b, 2'd1);
    fret(32'h55, 1'b1, 1'b0);
    fret(32'h66, 1'b1, 1'b0);
    step();
    chk("serr_cnt5", serr_a, 16'd5);
    chk("serr_b_sat", serr_b, 2'd3);
    ifa.out_rdy = 1'b0;

    // ready low blocks issue; then reset with reads in flight.
    ifa.ready = 1'b0; ifa.cl_read = 1'b1;
    step();
    chk("ready_blocks", last_gnt, 1'b0);
    ifa.ready = 1'b1; next_data = 32'hD0; gcnt = 0;
    repeat (4) step();
    chk("grants_pre_rst", gcnt, 4);
    ifa.cl_read = 1'b0; rst = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    step();
    chk("post_rst_vld", ifa.out_vld, 1'b0);
    chk("post_rst_ovf", ovf_a, 1'b0);
    chk("post_rst_serr", serr_a, 16'h0);
    chk("post_rst_derr_b", derr_b, 2'd0);
    next_data = 32'hE0; gcnt = 0; ifa.cl_read = 1'b1;
    repeat (10) step();
    chk("post_rst_credit", gcnt, 8);
    drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rdret_1r1we_rl2.md
Name: rdret_1r1we_rl2

Overview:
Read-return stage directly downstream of the 1r1we rl2 pseudo-DRAM memory top. It gates client read issue with a credit scheme so no read is issued without guaranteed return space. It captures the fixed-latency rd_vld/rd_dout/rd_fwrd/rd_serr/rd_derr/rd_padr return into a FIFO and presents it to the consumer with valid/ready backpressure. It also keeps saturating single/double-error counters and a sticky overflow flag.

Parameters:
WIDTH, 32, data width of the memory top
BITADDR, 13, address width
BITPADR, 14, physical address width reported on rd_padr
DEPTH, 8, return FIFO entries; must be at least 2
BITDEPTH, 3, log2(DEPTH)
BITCNT, 16, width of each error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ready  in  1  memory-top ready; no read is issued while low
cl_read  in  1  client read request
cl_rd_adr  in  BITADDR  client read address
cl_rd_gnt  out  1  combinational grant: cl_read & ready & (credit>0)
read  out  1  read strobe to memory top, equal to cl_rd_gnt
rd_adr  out  BITADDR  equal to cl_rd_adr
rd_vld  in  1  return valid from memory top
rd_dout  in  WIDTH  return data
rd_fwrd  in  1  forwarded-data flag
rd_serr  in  1  single-bit error corrected
rd_derr  in  1  double-bit error detected
rd_padr  in  BITPADR  physical address of the return
out_vld  out  1  FIFO head valid
out_rdy  in  1  consumer ready
out_dout  out  WIDTH  head data
out_fwrd  out  1  head forward flag
out_serr  out  1  head serr
out_derr  out  1  head derr
out_padr  out  BITPADR  head physical address
serr_cnt  out  BITCNT  saturating count of returns with rd_serr
derr_cnt  out  BITCNT  saturating count of returns with rd_derr
ovf  out  1  sticky flag: rd_vld arrived with FIFO full

Behaviour:
- Reset: one clock and one synchronous active-high reset. All outputs are 0 and all internal registers are 0 on the cycle after rst is sampled high. FIFO is emptied, credit is restored to DEPTH. A read in flight during reset is discarded: rd_vld is ignored while rst is high.
- Credit register, BITDEPTH+1 bits, reset value DEPTH:
  - Equals DEPTH minus (reads outstanding + FIFO occupancy).
  - Decrement on cl_rd_gnt; increment on a pop (out_vld & out_rdy).
  - Both in the same cycle: credit is unchanged.
  - Credit never exceeds DEPTH and never drops below 0.
- Grant: cl_rd_gnt is combinational and cycle-exact with read. No registering on the issue path.
- Push: on rd_vld write {dout,fwrd,serr,derr,padr} at the write pointer.
  - Pointers are BITDEPTH-bit and wrap modulo DEPTH.
  - Occupancy counter is BITDEPTH+1 bits.
- Pop: on out_vld & out_rdy.
- Push and pop in the same cycle are legal at any occupancy:
  - At full, pop-then-push: occupancy is unchanged, no overflow.
  - At empty, the push is not bypassed. out_vld rises the next cycle, so minimum return-to-out latency is 1 cycle.
- Outputs are read from FIFO storage at the read pointer. out_vld = (occupancy != 0). Head fields hold stable while out_vld & !out_rdy.
- Overflow: rd_vld while full with no pop in the same cycle:
  - The entry is dropped and ovf sets (sticky until rst).
  - Credit is still not incremented.
  - This is unreachable under correct credit use; it is a protocol-violation detector.
- Error counters: serr_cnt increments on rd_vld & rd_serr; derr_cnt increments on rd_vld & rd_derr. Both count at push time, including dropped entries, and saturate at all-ones.
- ready low blocks issue only. Returns already in flight are still accepted.

Decomposition:
- Shared package pkg_1r1we_rl2: return-entry struct {dout,fwrd,serr,derr,padr} and the localparam for entry width WIDTH+BITPADR+3.
- One natural sub-module: rdret_fifo_1r1we, a generic flop-array FIFO with push, pop, full, empty and count.
- Credit logic and error counters stay in the top.

Test Plan:
- Reset with DEPTH=8: after rst, cl_read=1 and ready=1 give 8 consecutive grants. The 9th cycle has cl_rd_gnt=0 while out_rdy=0 and all 8 returns are captured.
- Full FIFO with out_rdy=1 and cl_read=1: one grant per pop, credit stays at 0, FIFO returns the data in order (e.g. 0xA0..0xA7).
- Empty FIFO, rd_vld with dout=0x1234 in cycle N: out_vld=1 and out_dout=0x1234 in cycle N+1.
- Full FIFO with forced rd_vld and out_rdy=0: ovf=1 and stays 1, contents unchanged. Then rd_vld with out_rdy=1: no ovf change, head advances.
- rd_serr=1 on 3 returns and rd_derr=1 on 1 return: serr_cnt=3 and derr_cnt=1. With BITCNT=2 and 5 serr returns: serr_cnt saturates at 3.
- rst asserted with 4 reads outstanding: afterwards credit=DEPTH, out_vld=0, and late rd_vld pulses during rst are ignored.
